fmap_buffer: RTL

- Feature-map sink and read responder placed after a convolution layer.
- Write side accepts the conv layer's output stream (data, flat address, valid, done) into on-chip storage.
- Once the producer signals done, the buffer serves addressed reads, with a valid, to the next layer (pool or next conv), acting as its input memory.
- A fill/ready handshake guarantees a consumer never reads a partially written map.

---
 rtl/fmap_buffer_if.sv | 33 +++
 rtl/fmap_buffer.sv | 118 +++++++++++
 2 files changed

// File: rtl/fmap_buffer_if.sv
// Bus bundle for fmap_buffer: producer write stream, consumer read port, and status.
// Widths come from the instantiating context and must match the buffer's derived widths.
interface fmap_buffer_if #(
  parameter int ADDR_W     = 12,
  parameter int DATA_WIDTH = 16,
  parameter int CNT_W      = 12
);
  logic                  wr_valid;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_done;
  logic                  rd_en;
  logic [ADDR_W-1:0]     rd_addr;
  // 'release' is a reserved word, so the consumer-finished strobe carries a suffix.
  logic                  release_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  buf_ready;
  logic [CNT_W-1:0]      wr_count;
  logic                  incomplete;
  logic                  wr_err;
  logic                  rd_err;

  modport master (
    output wr_valid, wr_addr, wr_data, wr_done, rd_en, rd_addr, release_en,
    input  rd_data, rd_valid, buf_ready, wr_count, incomplete, wr_err, rd_err
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, wr_done, rd_en, rd_addr, release_en,
    output rd_data, rd_valid, buf_ready, wr_count, incomplete, wr_err, rd_err
  );
endinterface

// File: rtl/fmap_buffer.sv
// Feature-map buffer: collects a conv layer's output map, then serves it read-only
// to the next layer until released. A fill/ready FSM keeps reads off a partial map.
module fmap_buffer #(
  parameter  int MAP_WIDTH  = 62,
  parameter  int MAP_HEIGHT = 62,
  parameter  int NUM_MAPS   = 1,
  parameter  int DATA_WIDTH = 16,
  localparam int DEPTH      = MAP_WIDTH * MAP_HEIGHT * NUM_MAPS,
  localparam int ADDR_W     = $clog2(DEPTH),
  localparam int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  fmap_buffer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, FILL, READY} state_e;

  localparam logic [ADDR_W:0]  DEPTH_A = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      wr_count_q, wr_count_d;
  logic                  incomplete_q, incomplete_d;
  logic [ADDR_W-1:0]     last_addr_q, last_addr_d;
  logic                  have_last_q, have_last_d;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_valid_q, wr_err_q, rd_err_q;

  logic wr_in_range, rd_in_range, wr_accept, rd_accept, is_ready;

  assign is_ready    = (state_q == READY);
  assign wr_in_range = ({1'b0, bus.wr_addr} < DEPTH_A);
  assign rd_in_range = ({1'b0, bus.rd_addr} < DEPTH_A);
  assign wr_accept   = bus.wr_valid && wr_in_range && !is_ready;
  assign rd_accept   = bus.rd_en && rd_in_range && is_ready;

  // NOTE: every always_comb target gets a default first so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    wr_count_d   = wr_count_q;
    incomplete_d = incomplete_q;
    last_addr_d  = last_addr_q;
    have_last_d  = have_last_q;

    // A held write on the same address refreshes memory but is not a new pixel.
    if (wr_accept) begin
      if ((!have_last_q || bus.wr_addr != last_addr_q) && wr_count_q != DEPTH_C)
        wr_count_d = wr_count_q + 1'b1;
      last_addr_d = bus.wr_addr;
      have_last_d = 1'b1;
    end

    case (state_q)
      IDLE, FILL: begin
        if (bus.wr_done) begin
          state_d      = READY;
          incomplete_d = (wr_count_d != DEPTH_C);
        end else if (wr_accept) begin
          state_d = FILL;
        end
      end
      READY: begin
        if (bus.release_en) begin
          state_d      = IDLE;
          wr_count_d   = '0;
          incomplete_d = 1'b0;
          last_addr_d  = '0;
          have_last_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      wr_count_q   <= '0;
      incomplete_q <= 1'b0;
      last_addr_q  <= '0;
      have_last_q  <= 1'b0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      wr_err_q     <= 1'b0;
      rd_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_count_q   <= wr_count_d;
      incomplete_q <= incomplete_d;
      last_addr_q  <= last_addr_d;
      have_last_q  <= have_last_d;
      rd_valid_q   <= rd_accept;
      wr_err_q     <= bus.wr_valid && !wr_accept;
      rd_err_q     <= bus.rd_en && !rd_accept;
      if (rd_accept)
        rd_data_q <= mem[bus.rd_addr];
    end
  end

  // NOTE: storage has no reset; the count and FSM decide which words are meaningful.
  always_ff @(posedge clk) begin
    if (wr_accept)
      mem[bus.wr_addr] <= bus.wr_data;
  end

  assign bus.rd_data    = rd_data_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.buf_ready  = is_ready;
  assign bus.wr_count   = wr_count_q;
  assign bus.incomplete = incomplete_q;
  assign bus.wr_err     = wr_err_q;
  assign bus.rd_err     = rd_err_q;

endmodule
